// File: rtl/melody_sequencer_if.sv
// ---------------------------------------------------------------------------
// melody_sequencer_if
// Groups the song-memory write port, the play controls and the player status
// of melody_sequencer.
//   wr_en / wr_addr / wr_data : song memory write strobe, address, {note,dur}
//   start / stop              : play request, abort request
//   note                      : 5-bit note code to the speaker stage
//   busy / done / pos         : not-idle flag, end-of-song pulse, entry index
// master drives the controls and the write port; slave is the sequencer.
// ---------------------------------------------------------------------------
interface melody_sequencer_if;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [8:0] wr_data;
   logic       start;
   logic       stop;
   logic [4:0] note;
   logic       busy;
   logic       done;
   logic [4:0] pos;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop,
      input  note, busy, done, pos
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop,
      output note, busy, done, pos
   );
endinterface

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
// Steps through a 32 x 9-bit song memory ({note[8:4], dur[3:0]}) and drives
// the note code of the square-wave speaker stage. dur = 0 ends the song.
// Each entry takes FETCH, LOAD, then dur*UNIT_CYCLES PLAY cycles, the last
// GAP_CYCLES of which are silent.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus_io : melody_sequencer_if.slave (write port, start/stop, note, busy,
//            done, pos)
// Build option: define MELODY_LOOP_EN to repeat the song until stop; an end
// marker at address 0 still returns to idle so an empty song cannot spin.
// ---------------------------------------------------------------------------
module melody_sequencer #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned UNIT_HZ    = 16,
   parameter int unsigned GAP_CYCLES = 1_000_000
) (
   input logic               clk,
   input logic               reset,
   melody_sequencer_if.slave bus_io
);

   localparam int unsigned UNIT_CYCLES = CLK_HZ / UNIT_HZ;
   localparam int unsigned CW          = $clog2(15 * UNIT_CYCLES);
   localparam logic [CW-1:0] UNIT_C    = CW'(UNIT_CYCLES);
   localparam logic [CW-1:0] GAP_C     = CW'(GAP_CYCLES);
   localparam logic [CW-1:0] ONE_C     = CW'(1'b1);
   localparam logic [CW-1:0] ZERO_C    = CW'(1'b0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_PLAY  = 2'd3;

   logic [8:0]    mem_q [0:31];
   logic [8:0]    rd_q;

   logic [1:0]    state_q, state_d;
   logic [4:0]    pos_q, pos_d;
   logic          wrap_q, wrap_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    code_q, code_d;
   logic [4:0]    note_q, note_d;
   logic          done_q, done_d;
   logic          busy_q;

   logic [CW-1:0] dur_s;
   logic [CW-1:0] load_s;
   logic          end_s;

   // Song memory: write port plus one-cycle-latency read of the entry at pos
   always_ff @(posedge clk) begin
      if (bus_io.wr_en) begin
         mem_q[bus_io.wr_addr] <= bus_io.wr_data;
      end
      rd_q <= mem_q[pos_q];
   end

   assign dur_s  = CW'(rd_q[3:0]);
   assign load_s = (dur_s * UNIT_C) - ONE_C;
   // A wrapped pos means all 32 entries have played, whatever entry 0 holds.
   assign end_s  = (rd_q[3:0] == 4'd0) || wrap_q;

`ifdef MELODY_LOOP_EN
   logic empty_s;
   assign empty_s = (pos_q == 5'd0) && !wrap_q;
`endif

   // Next-state logic of the player; stop overrides everything, start included
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      wrap_d  = wrap_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      note_d  = 5'd0;
      done_d  = 1'b0;
      if (bus_io.stop) begin
         state_d = S_IDLE;
         pos_d   = 5'd0;
         wrap_d  = 1'b0;
         cnt_d   = ZERO_C;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus_io.start) begin
                  state_d = S_FETCH;
                  pos_d   = 5'd0;
                  wrap_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FETCH: begin
               state_d = S_LOAD;
            end
            S_LOAD: begin
               if (end_s) begin
                  done_d = 1'b1;
                  wrap_d = 1'b0;
`ifdef MELODY_LOOP_EN
                  if (empty_s) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_FETCH;
                     pos_d   = 5'd0;
                  end
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  // GAP_CYCLES < UNIT_CYCLES, so the first PLAY cycle always sounds
                  cnt_d   = load_s;
                  code_d  = rd_q[8:4];
                  note_d  = rd_q[8:4];
                  state_d = S_PLAY;
               end
            end
            S_PLAY: begin
               if (cnt_q == ZERO_C) begin
                  pos_d   = pos_q + 5'd1;
                  wrap_d  = (pos_q == 5'd31);
                  state_d = S_FETCH;
               end else begin
                  cnt_d = cnt_q - ONE_C;
                  // note_q shows the value for the next count, cnt_q - 1
                  if (cnt_q > GAP_C) begin
                     note_d = code_q;
                  end else begin
                     note_d = 5'd0;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               pos_d   = 5'd0;
               wrap_d  = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pos_q   <= 5'd0;
         wrap_q  <= 1'b0;
         cnt_q   <= ZERO_C;
         code_q  <= 5'd0;
         note_q  <= 5'd0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         note_q  <= note_d;
         done_q  <= done_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign bus_io.note = note_q;
   assign bus_io.busy = busy_q;
   assign bus_io.done = done_q;
   assign bus_io.pos  = pos_q;

endmodule
